// File: rtl/ahb_multi_slave_mux.sv
// AHB-Lite slave multiplexer: address decode, data-phase response mux
// and a built-in default slave that answers unmapped transfers with ERROR.
module ahb_multi_slave_mux #(
    parameter int NUM_SLAVES = 3,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE =
        {32'h8001_0000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK =
        {32'hFFFF_0000, 32'hFFFF_0000, 32'h8000_0000}
) (
    input  logic                             clk,
    input  logic                             async_reset,
    input  logic [31:0]                      HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    input  logic                             HMASTLOCK,
    input  logic [2:0]                       HSIZE,
    input  logic [2:0]                       HBURST,
    input  logic [3:0]                       HPROT,
    input  logic [DATA_WIDTH-1:0]            HWDATA,
    output logic                             HREADY,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic [1:0]                       HRESP,
    output logic [NUM_SLAVES-1:0]            HSEL_s,
    input  logic [NUM_SLAVES-1:0]            HREADYOUT_s,
    input  logic [NUM_SLAVES-1:0]            HRESP_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_s,
    output logic [15:0]                      err_count
);

    localparam logic [1:0] TR_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERR1,
        ST_ERR2
    } st_e;

    st_e             st_q, st_d;
    logic            dp_vld_q, dp_vld_d;
    logic [2:0]      dp_idx_q, dp_idx_d;
    logic [15:0]     err_q, err_d;

    logic            hit;
    logic [2:0]      win_idx;
    logic            slv_rdy;
    logic            slv_rsp;
    logic [DATA_WIDTH-1:0] slv_rd;
    logic            hready;
    logic            rsp0;
    logic [DATA_WIDTH-1:0] rdata;
    logic            load_slv;
    logic            load_def;

    // Control signals are forwarded to slaves by wiring outside this block.
    logic unused_ctrl;
    assign unused_ctrl = ^{HWRITE, HMASTLOCK, HSIZE,
                           HBURST, HPROT, HWDATA};

    // Address decode; the downward scan lets the lowest index win.
    always_comb begin
        hit     = 1'b0;
        win_idx = 3'd0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                win_idx = i[2:0];
            end
        end
    end

    // Select only for real transfers (NONSEQ/SEQ).
    always_comb begin
        HSEL_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            HSEL_s[i] = hit && HTRANS[1] && (win_idx == i[2:0]);
        end
    end

    // Response from the slave that owns the data phase.
    always_comb begin
        slv_rdy = 1'b1;
        slv_rsp = 1'b0;
        slv_rd  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dp_vld_q && dp_idx_q == i[2:0]) begin
                slv_rdy = HREADYOUT_s[i];
                slv_rsp = HRESP_s[i];
                slv_rd  = HRDATA_s[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Default-slave outputs, then next state of owner, FSM and counter.
    always_comb begin
        hready   = slv_rdy;
        rsp0     = slv_rsp;
        rdata    = slv_rd;
        st_d     = st_q;
        dp_vld_d = dp_vld_q;
        dp_idx_d = dp_idx_q;
        err_d    = err_q;
        unique case (st_q)
            ST_ERR1: begin
                hready = 1'b0;
                rsp0   = 1'b1;
                rdata  = '0;
            end
            ST_ERR2: begin
                hready = 1'b1;
                rsp0   = 1'b1;
                rdata  = '0;
            end
            default: ;
        endcase
        load_slv = hready && (HTRANS != TR_IDLE) && hit;
        load_def = hready && HTRANS[1] && !hit;
        if (hready) begin
            dp_vld_d = load_slv;
            dp_idx_d = win_idx;
        end
        unique case (st_q)
            ST_IDLE: if (load_def) st_d = ST_ERR1;
            ST_ERR1: st_d = ST_ERR2;
            ST_ERR2: st_d = load_def ? ST_ERR1 : ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        if (load_def && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    // State registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            st_q     <= ST_IDLE;
            dp_vld_q <= 1'b0;
            dp_idx_q <= 3'd0;
            err_q    <= 16'd0;
        end else begin
            st_q     <= st_d;
            dp_vld_q <= dp_vld_d;
            dp_idx_q <= dp_idx_d;
            err_q    <= err_d;
        end
    end

    assign HREADY    = hready;
    assign HRDATA    = rdata;
    assign HRESP     = {1'b0, rsp0};
    assign err_count = err_q;

endmodule

// File: tb/tb_ahb_multi_slave_mux.sv
// Directed bench for ahb_multi_slave_mux: decode, wait states,
// default-slave error responses, counter saturation and reset.
module tb_ahb_multi_slave_mux;

    logic        clk;
    logic        async_reset;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HMASTLOCK;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic [2:0]  HSEL_s;
    logic [2:0]  HREADYOUT_s;
    logic [2:0]  HRESP_s;
    logic [95:0] HRDATA_s;
    logic [15:0] err_count;

    int n_vec;
    int n_miss;

    ahb_multi_slave_mux dut (
        .clk         (clk),
        .async_reset (async_reset),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HMASTLOCK   (HMASTLOCK),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HWDATA      (HWDATA),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HSEL_s      (HSEL_s),
        .HREADYOUT_s (HREADYOUT_s),
        .HRESP_s     (HRESP_s),
        .HRDATA_s    (HRDATA_s),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        async_reset = 1'b0;
        HTRANS      = 2'b00;
        step();
        async_reset = 1'b1;
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        async_reset = 1'b0;
        HADDR       = 32'h0000_0040;
        HTRANS      = 2'b10;
        HWRITE      = 1'b0;
        HMASTLOCK   = 1'b1;
        HSIZE       = 3'b010;
        HBURST      = 3'b000;
        HPROT       = 4'b0011;
        HWDATA      = 32'h0;
        HREADYOUT_s = 3'b111;
        HRESP_s     = 3'b000;
        HRDATA_s    = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        #1;
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_hsel", 32'(HSEL_s), 32'b001);
        step();
        step();
        HTRANS = 2'b00;
        async_reset = 1'b1;

        // Read from slave 0
        step();
        HADDR  = 32'h0000_0040;
        HTRANS = 2'b10;
        #1 chk("rd0_hsel", 32'(HSEL_s), 32'b001);
        step();
        HTRANS = 2'b00;
        #1;
        chk("rd0_hrdata", HRDATA, 32'hDEAD_BEEF);
        chk("rd0_hresp", 32'(HRESP), 32'd0);
        chk("rd0_hready", 32'(HREADY), 32'd1);

        // Write to slave 1 with two wait states
        step();
        HADDR  = 32'h8000_0004;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        #1 chk("wr1_hsel", 32'(HSEL_s), 32'b010);
        step();
        HREADYOUT_s = 3'b101;
        HADDR  = 32'h8001_0000;
        HWRITE = 1'b0;
        #1;
        chk("ws1_hready", 32'(HREADY), 32'd0);
        chk("ws1_hsel2", 32'(HSEL_s), 32'b100);
        chk("ws1_hrdata", HRDATA, 32'h1111_1111);
        step();
        #1;
        chk("ws2_hready", 32'(HREADY), 32'd0);
        chk("ws2_hrdata", HRDATA, 32'h1111_1111);
        step();
        HREADYOUT_s = 3'b111;
        #1;
        chk("ws3_hready", 32'(HREADY), 32'd1);
        chk("ws3_hrdata", HRDATA, 32'h1111_1111);
        step();
        HTRANS = 2'b00;
        #1;
        chk("s2_hrdata", HRDATA, 32'h2222_2222);
        chk("s2_hready", 32'(HREADY), 32'd1);

        // Single unmapped transfer
        step();
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b10;
        #1 chk("um_hsel", 32'(HSEL_s), 32'b000);
        step();
        HTRANS = 2'b00;
        #1;
        chk("um_e1_hready", 32'(HREADY), 32'd0);
        chk("um_e1_hresp", 32'(HRESP), 32'd1);
        chk("um_e1_hrdata", HRDATA, 32'h0);
        step();
        #1;
        chk("um_e2_hready", 32'(HREADY), 32'd1);
        chk("um_e2_hresp", 32'(HRESP), 32'd1);
        chk("um_err", 32'(err_count), 32'd1);
        step();
        #1;
        chk("um_end_hresp", 32'(HRESP), 32'd0);
        chk("um_end_hready", 32'(HREADY), 32'd1);

        // Three back-to-back unmapped SEQ transfers
        do_reset();
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b11;
        #1 chk("b2b_hsel", 32'(HSEL_s), 32'b000);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk($sformatf("b2b%0d_e1_hready", k), 32'(HREADY), 32'd0);
            chk($sformatf("b2b%0d_e1_hresp", k), 32'(HRESP), 32'd1);
            chk($sformatf("b2b%0d_err", k), 32'(err_count), 32'(k + 1));
            step();
            if (k == 2) HTRANS = 2'b00;
            #1;
            chk($sformatf("b2b%0d_e2_hready", k), 32'(HREADY), 32'd1);
            chk($sformatf("b2b%0d_e2_hresp", k), 32'(HRESP), 32'd1);
        end
        step();
        #1;
        chk("b2b_end_hresp", 32'(HRESP), 32'd0);
        chk("b2b_end_err", 32'(err_count), 32'd3);

        // IDLE and BUSY phases
        step();
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b00;
        #1;
        chk("idle_hsel", 32'(HSEL_s), 32'b000);
        chk("idle_hready", 32'(HREADY), 32'd1);
        step();
        HADDR  = 32'h8000_0000;
        HTRANS = 2'b01;
        #1;
        chk("busy_hsel", 32'(HSEL_s), 32'b000);
        chk("busy_hresp", 32'(HRESP), 32'd0);
        step();
        HTRANS = 2'b00;
        #1;
        chk("busy_dp_hready", 32'(HREADY), 32'd1);
        chk("busy_dp_hresp", 32'(HRESP), 32'd0);
        chk("busy_err", 32'(err_count), 32'd3);

        // Saturation, then reset during an error response
        step();
        force dut.err_q = 16'hFFFE;
        #1 release dut.err_q;
        chk("pre_err", 32'(err_count), 32'hFFFE);
        HADDR  = 32'hC000_0000;
        HTRANS = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            step();
        end
        HTRANS = 2'b10;
        #1 chk("sat_err3", 32'(err_count), 32'hFFFF);
        step();
        HTRANS = 2'b00;
        #1;
        chk("sat_e1_hready", 32'(HREADY), 32'd0);
        chk("sat_err4", 32'(err_count), 32'hFFFF);
        #2 async_reset = 1'b0;
        #1;
        chk("mid_rst_hready", 32'(HREADY), 32'd1);
        chk("mid_rst_hresp", 32'(HRESP), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        step();
        async_reset = 1'b1;
        HADDR  = 32'h0000_0040;
        HTRANS = 2'b10;
        #1 chk("post_hsel", 32'(HSEL_s), 32'b001);
        step();
        HTRANS = 2'b00;
        #1;
        chk("post_hrdata", HRDATA, 32'hDEAD_BEEF);
        chk("post_hresp", 32'(HRESP), 32'd0);
        chk("post_err", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule
